nanov_spi_fetch: RTL
====================

Name: nanov_spi_fetch

Overview:
- SPI instruction-fetch front end for the bit-serial nanoV CPU; sits directly upstream of the CPU's instruction register.
- Issues a flash READ command plus a 24-bit address, then streams 32-bit little-endian instruction words to the CPU over a valid/ready handshake.
- Stalls the SPI clock when the consumer back-pressures. Restarts the stream on a branch redirect.

Parameters:
- RESET_ADDR, 24'h000000, fetch address used after reset; bits [1:0] forced to 0.
- READ_CMD, 8'h03, SPI read opcode sent MSB first.
- DUMMY_CYCLES, 0, idle clock cycles between the address and the first data bit (0..15).

Ports:
- clk  in  1  system clock; SPI SCK = clk gated by spi_clk_en (external gate).
- rstn  in  1  reset: synchronous, active-low.
- redirect_valid  in  1  restart fetch at redirect_addr (taken branch/jump).
- redirect_addr  in  24  new byte address; bits [1:0] ignored (treated as 0).
- instr_valid  out  1  instr_data/instr_addr hold a fetched word.
- instr_ready  in  1  consumer accepts the word this cycle when instr_valid=1.
- instr_data  out  32  fetched instruction; byte at addr → [7:0], addr+1 → [15:8], and so on.
- instr_addr  out  24  byte address of instr_data.
- spi_select  out  1  flash chip select, active low.
- spi_clk_en  out  1  SCK pulse enable for this cycle.
- spi_out  out  1  MOSI, changes after a clk rising edge.
- spi_data_in  in  1  MISO, sampled on clk rising edges where spi_clk_en=1.

Behaviour:
- Reset values (registered while rstn=0):
  - spi_select=1, spi_clk_en=0, spi_out=0, instr_valid=0, instr_data=0, instr_addr=0.
  - Pending fetch address = RESET_ADDR. State = DESELECT.
- States: DESELECT → CMD → ADDR → DUMMY (skipped if DUMMY_CYCLES=0) → DATA.
- DESELECT:
  - Exactly 1 cycle; spi_select=1, spi_clk_en=0. Then → CMD.
- CMD:
  - 8 cycles; spi_select=0, spi_clk_en=1.
  - spi_out presents READ_CMD[7] first, down to [0].
- ADDR:
  - 24 cycles; fetch address presented MSB first (bit 23 first).
- DUMMY:
  - DUMMY_CYCLES cycles; spi_out=0, spi_clk_en=1.
- DATA:
  - spi_out=0. Each enabled cycle samples one bit into the word shift register.
  - Each byte arrives MSB first; bytes are placed little-endian.
  - Bit counter 0..31 wraps; the flash auto-increments its address, so CS stays low across words.
- Word complete (32nd bit sampled):
  - If the output register is empty, or it is handed off this cycle (instr_valid && instr_ready): the word transfers to instr_data on that edge, instr_valid=1, instr_addr=word address.
  - Otherwise the word stays pending in the shift register.
  - Word address increments by 4 per completed word and wraps modulo 2^24.
- Stall:
  - While a pending word exists, spi_clk_en=0 and spi_select stays 0. No sampling and no bit-counter advance.
  - On the cycle the output register frees, the pending word moves in (instr_valid stays 1 with new data). spi_clk_en returns to 1 on the next cycle.
- Handshake:
  - instr_data/instr_addr are stable while instr_valid=1 and !instr_ready.
  - instr_valid drops after acceptance unless a new word transfers on the same edge.
- Latency:
  - Redirect sampled at edge E0 → DESELECT after E0 → first word valid after edge E(65+DUMMY_CYCLES).
  - Steady state, with instr_ready held at 1: one word per 32 cycles.
- Redirect (any state, including mid-word, stalled, or DESELECT):
  - At the next edge: state=DESELECT, spi_select=1, spi_clk_en=0, instr_valid=0.
  - Pending word and partial bits are discarded; fetch address = {redirect_addr[23:2],2'b00}.
  - Redirect has priority over a same-cycle handshake. The consumer treats that word as accepted; the block does not re-present it.
- Back-to-back redirects: each one restarts; the last address wins.
- rstn low mid-transfer: reset values apply at the next edge; a new fetch at RESET_ADDR begins after reset is released.

Test Plan:
- Reset release, RESET_ADDR=0, flash model holding 0x00000013 at 0, instr_ready=1 → spi_select falls 1 cycle after reset release. MOSI carries 0x03 then 0x000000. instr_valid rises 65 cycles after the reset-release edge with instr_data=0x00000013, instr_addr=0.
- Flash bytes 0x93,0x00,0x10,0x00 at address 4 → instr_data=0x00100093, instr_addr=4. The next word follows 32 cycles later with instr_addr=8.
- Hold instr_ready=0 for 100 cycles after the first word → second word completes and is held pending. spi_clk_en=0 while spi_select=0, instr_data unchanged. After ready=1, the second word appears on the next edge and SCK resumes one cycle later.
- redirect_valid with redirect_addr=0x000123 mid-DATA (bit 17) → next edge spi_select=1 and instr_valid=0. MOSI then carries 0x03, 0x000120. The first word after redirect has instr_addr=0x000120.
- Redirect in the same cycle as instr_valid&&instr_ready, plus two consecutive redirects (0x40 then 0x80) → only the 0x80 stream is issued; no stale word is presented.
- DUMMY_CYCLES=8, address 0xFFFFFC → first valid after 73 cycles. The next instr_addr wraps to 0x000000.

Source files
------------

// File: rtl/nanov_spi_fetch_if.sv
// Fetch front-end bundle: redirect request, instruction valid/ready stream, SPI flash pins.
// master: the fetch engine (drives instr_* and spi_select/spi_clk_en/spi_out).
// slave : the CPU + flash side (drives redirect_*, instr_ready, spi_data_in).
interface nanov_spi_fetch_if;
  logic        redirect_valid;
  logic [23:0] redirect_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [23:0] instr_addr;
  logic        spi_select;
  logic        spi_clk_en;
  logic        spi_out;
  logic        spi_data_in;

  modport master (
    input  redirect_valid, redirect_addr, instr_ready, spi_data_in,
    output instr_valid, instr_data, instr_addr, spi_select, spi_clk_en, spi_out
  );

  modport slave (
    output redirect_valid, redirect_addr, instr_ready, spi_data_in,
    input  instr_valid, instr_data, instr_addr, spi_select, spi_clk_en, spi_out
  );
endinterface

// File: rtl/nanov_spi_fetch.sv
// SPI instruction fetch: sends READ_CMD + 24-bit address, streams 32-bit little-endian words.
// Latency: first word valid 65+DUMMY_CYCLES edges after reset/redirect, then one word per 32 cycles.
// Backpressure: a finished word waits in the shift register and SCK stops until the output frees.
// Ports: clk, rstn (sync, active-low), bus (nanov_spi_fetch_if.master): redirect_valid/addr in,
//        instr_valid/data/addr out with instr_ready in, spi_select/spi_clk_en/spi_out out, spi_data_in in.
module nanov_spi_fetch #(
  parameter logic [23:0] RESET_ADDR   = 24'h000000,
  parameter logic [7:0]  READ_CMD     = 8'h03,
  parameter int unsigned DUMMY_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rstn,
  nanov_spi_fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_DESELECT,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA
  } state_t;

  localparam logic [4:0] DUMMY_LAST = (DUMMY_CYCLES > 0) ? 5'(DUMMY_CYCLES - 1) : 5'd0;

  state_t      state;
  state_t      state_nxt;

  logic [4:0]  cnt;          // bit position within the current phase
  logic [31:0] cmd_sr;       // opcode + address, shifted out MSB first
  logic [23:0] fetch_addr;   // address of the word currently being received
  logic [31:0] word_sr;      // word being assembled, or the pending word while stalled
  logic [31:0] word_nxt;
  logic        pend;         // word_sr holds a complete word not yet handed over
  logic [23:0] pend_addr;

  logic        out_vld;
  logic [31:0] out_dat;
  logic [23:0] out_addr;

  logic        sel;
  logic        sck_en;
  logic        mosi;
  logic        handoff;

  assign handoff = out_vld && bus.instr_ready;

  // Bytes arrive MSB first and are placed little-endian: bit b of the stream
  // lands in byte b/8, bit position 7-(b%8).
  always_comb begin
    word_nxt = word_sr;
    word_nxt[{cnt[4:3], ~cnt[2:0]}] = bus.spi_data_in;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_DESELECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel       = 1'b1;
    sck_en    = 1'b0;
    mosi      = 1'b0;

    case (state)
      S_DESELECT: begin
        state_nxt = S_CMD;
      end
      S_CMD: begin
        sel    = 1'b0;
        sck_en = 1'b1;
        mosi   = cmd_sr[31];
        if (cnt == 5'd7) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        sel    = 1'b0;
        sck_en = 1'b1;
        mosi   = cmd_sr[31];
        if (cnt == 5'd23) state_nxt = (DUMMY_CYCLES > 0) ? S_DUMMY : S_DATA;
      end
      S_DUMMY: begin
        sel    = 1'b0;
        sck_en = 1'b1;
        if (cnt == DUMMY_LAST) state_nxt = S_DATA;
      end
      S_DATA: begin
        sel    = 1'b0;
        // CS stays low during a stall so the flash keeps its read position.
        sck_en = !pend;
      end
      default: begin
        state_nxt = S_DESELECT;
      end
    endcase

    if (bus.redirect_valid) state_nxt = S_DESELECT;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt        <= 5'd0;
      cmd_sr     <= 32'd0;
      fetch_addr <= RESET_ADDR & 24'hFFFFFC;
      word_sr    <= 32'd0;
      pend       <= 1'b0;
      pend_addr  <= 24'd0;
      out_vld    <= 1'b0;
      out_dat    <= 32'd0;
      out_addr   <= 24'd0;
    end else if (bus.redirect_valid) begin
      // A redirect wins over a same-cycle handshake; in-flight data is dropped.
      fetch_addr <= bus.redirect_addr & 24'hFFFFFC;
      cnt        <= 5'd0;
      pend       <= 1'b0;
      out_vld    <= 1'b0;
    end else begin
      if (handoff) out_vld <= 1'b0;

      case (state)
        S_DESELECT: begin
          cmd_sr <= {READ_CMD, fetch_addr};
          cnt    <= 5'd0;
        end
        S_CMD: begin
          cmd_sr <= {cmd_sr[30:0], 1'b0};
          cnt    <= (cnt == 5'd7) ? 5'd0 : cnt + 5'd1;
        end
        S_ADDR: begin
          cmd_sr <= {cmd_sr[30:0], 1'b0};
          cnt    <= (cnt == 5'd23) ? 5'd0 : cnt + 5'd1;
        end
        S_DUMMY: begin
          cnt <= (cnt == DUMMY_LAST) ? 5'd0 : cnt + 5'd1;
        end
        S_DATA: begin
          if (pend) begin
            if (handoff) begin
              out_vld  <= 1'b1;
              out_dat  <= word_sr;
              out_addr <= pend_addr;
              pend     <= 1'b0;
            end
          end else begin
            word_sr <= word_nxt;
            cnt     <= cnt + 5'd1;   // wraps 31 -> 0; flash auto-increments
            if (cnt == 5'd31) begin
              fetch_addr <= fetch_addr + 24'd4;
              if (!out_vld || handoff) begin
                out_vld  <= 1'b1;
                out_dat  <= word_nxt;
                out_addr <= fetch_addr;
              end else begin
                pend      <= 1'b1;
                pend_addr <= fetch_addr;
              end
            end
          end
        end
        default: begin
          cnt <= 5'd0;
        end
      endcase
    end
  end

  assign bus.instr_valid = out_vld;
  assign bus.instr_data  = out_dat;
  assign bus.instr_addr  = out_addr;
  assign bus.spi_select  = sel;
  assign bus.spi_clk_en  = sck_en;
  assign bus.spi_out     = mosi;

endmodule
